// File: rtl/regfile_dual_read.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dual_read
// Description : 32x32 MIPS register file, one write port, two pipelined read
//               ports with same-cycle write-through bypass; reg 0 reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dual_read #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RW,
    input  logic              E,
    input  logic [DATA_W-1:0] PW,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] PA,
    output logic [DATA_W-1:0] PB,
    output logic              rd_valid
);

    localparam logic [ADDR_W-1:0] c_zero_addr = '0;

    logic [DATA_W-1:0] w_regs [NUM_REGS];
    logic [DATA_W-1:0] w_val_a;
    logic [DATA_W-1:0] w_val_b;
    logic              w_byp_a;
    logic              w_byp_b;
    logic [DATA_W-1:0] r_pa;
    logic [DATA_W-1:0] r_pb;
    logic              r_valid;

    // Entry 0 is a constant, so $zero has no flops behind it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic              w_we;
                logic [DATA_W-1:0] r_q;

                assign w_we = E && (RW == ADDR_W'(gi));

                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_q <= '0;
                    end else if (w_we) begin
                        r_q <= PW;
                    end
                end

                assign w_regs[gi] = r_q;
            end
        end
    endgenerate

    // A write landing this cycle wins over the stale stored value.
    assign w_byp_a = E && (RW == RA) && (RA != c_zero_addr);
    assign w_byp_b = E && (RW == RB) && (RB != c_zero_addr);
    assign w_val_a = w_byp_a ? PW : w_regs[RA];
    assign w_val_b = w_byp_b ? PW : w_regs[RB];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pa    <= '0;
            r_pb    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_req;
            if (rd_req) begin
                r_pa <= w_val_a;
                r_pb <= w_val_b;
            end
        end
    end

    assign PA       = r_pa;
    assign PB       = r_pb;
    assign rd_valid = r_valid;

endmodule
`default_nettype wire
